addsub_arbiter: RTL and testbench
=================================

ADDSUB_ARBITER -- requirements
Module: addsub_arbiter

Interface
REQ-001 The block SHALL have no parameters; operand width is fixed at 4 bits and result width at 5 bits.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req_valid  input  2  per-requester request strobe; bit i belongs to requester i.
REQ-005 req_ready  output  2  per-requester accept; a request is accepted on a cycle with req_valid[i] & req_ready[i].
REQ-006 req_a0, req_b0  input  4 each  requester 0 operands, unsigned.
REQ-007 req_a1, req_b1  input  4 each  requester 1 operands, unsigned.
REQ-008 req_sub  input  2  per-requester operation select: 0 add, 1 subtract.
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_ready  input  1  consumer accepts result; transfer on rsp_valid & rsp_ready.
REQ-011 rsp_id  output  1  index of the requester that owns rsp_result.
REQ-012 rsp_result  output  5  operation result.

Function
REQ-013 The FSM SHALL have three states: IDLE, EXEC, RESP.
REQ-014 IDLE, no req_valid bit set: stay in IDLE; req_ready = 2'b00.
REQ-015 IDLE, any req_valid bit set: req_ready SHALL be one-hot on the granted requester in the same cycle (combinational from state, req_valid and pointer); operands, op select and id latched; next state EXEC.
REQ-016 Grant rule: one valid -> that requester; both valid -> the requester not granted last (round-robin pointer).
REQ-017 Pointer SHALL update only on acceptance, to the accepted id.
REQ-018 EXEC: latched operands drive the single shared adder/subtractor; its 5-bit output is registered into rsp_result; next state RESP. req_ready = 0.
REQ-019 RESP: rsp_valid = 1; rsp_id, rsp_result held stable until transfer; on rsp_ready next state IDLE. req_ready = 0.
REQ-020 Add: rsp_result = A + B, range 0..30, bit 4 is carry.
REQ-021 Subtract: rsp_result = ({0,A} - {0,B}) mod 32, i.e. 5-bit two's complement; bit 4 = 1 iff A < B.
REQ-022 Latency: acceptance in cycle N -> rsp_valid asserted in cycle N+2; max throughput one operation per 3 cycles.
REQ-023 A new request SHALL NOT be accepted in the cycle a response transfers; earliest next acceptance is the following cycle (IDLE).
REQ-024 req_valid deasserted by a requester while not granted SHALL have no effect; operand changes after acceptance SHALL not affect the in-flight result.

Reset
REQ-025 rst high at a clock edge SHALL force IDLE, rsp_valid = 0, rsp_id = 0, rsp_result = 0, req_ready = 0, latched operands = 0, pointer = 1 (so requester 0 wins the first tie).
REQ-026 rst in EXEC or RESP SHALL discard the in-flight operation; no response for it is ever produced.

Structure
REQ-027 A shared package SHALL hold the FSM state enum (IDLE, EXEC, RESP) and the width constants OPERAND_W = 4, RESULT_W = 5.
REQ-028 The block SHALL instantiate the existing 4-bit ripple adder_subtractor exactly once as its sole arithmetic sub-module; no other arithmetic operators on the datapath.

Verification
REQ-029 Requester 0 only, A=9, B=8, add -> req_ready=2'b01 that cycle, rsp_valid 2 cycles later, rsp_id=0, rsp_result=5'd17.
REQ-030 Requester 1 only, A=3, B=5, subtract -> rsp_id=1, rsp_result=5'b11110; A=7, B=7 subtract -> 5'b00000.
REQ-031 Both valid continuously after reset, ops 1+1 (req0) and 15+15 (req1) -> grants alternate 0,1,0,...; results 5'd2 (id 0), 5'd30 (id 1).
REQ-032 rsp_ready held low 4 cycles in RESP -> rsp_valid, rsp_id, rsp_result stable all 4 cycles; req_ready stays 0; single transfer when rsp_ready rises.
REQ-033 rst asserted in EXEC -> next cycle IDLE, rsp_valid=0, no response for that operation; next simultaneous request grants requester 0.

Source files
------------

// File: rtl/addsub_arbiter_pkg.sv
// rtl/addsub_arbiter_pkg.sv - shared FSM states and datapath widths for the add/sub arbiter
package addsub_arbiter_pkg;

  localparam int OPERAND_W = 4;
  localparam int RESULT_W  = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/addsub_arbiter_adder_subtractor.sv
// rtl/addsub_arbiter_adder_subtractor.sv - 4-bit ripple adder/subtractor with 5-bit result
module adder_subtractor
  import addsub_arbiter_pkg::*;
(
  input  logic [OPERAND_W-1:0] a_i,
  input  logic [OPERAND_W-1:0] b_i,
  input  logic                 sub_i,
  output logic [RESULT_W-1:0]  result_o
);

  logic [OPERAND_W:0]   carry;
  logic [OPERAND_W-1:0] b_x;
  logic [OPERAND_W-1:0] sum;

  assign b_x      = b_i ^ {OPERAND_W{sub_i}};
  assign carry[0] = sub_i;

  for (genvar i = 0; i < OPERAND_W; i++) begin : g_bit
    assign sum[i]     = a_i[i] ^ b_x[i] ^ carry[i];
    assign carry[i+1] = (a_i[i] & b_x[i]) | (carry[i] & (a_i[i] ^ b_x[i]));
  end

  // Subtract leaves carry-out set when no borrow, so invert it to get the 5-bit two's complement sign.
  assign result_o = {carry[OPERAND_W] ^ sub_i, sum};

endmodule

// File: rtl/addsub_arbiter.sv
// rtl/addsub_arbiter.sv - two-requester round-robin arbiter in front of one shared adder/subtractor
module addsub_arbiter
  import addsub_arbiter_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [OPERAND_W-1:0] req_a0,
  input  logic [OPERAND_W-1:0] req_b0,
  input  logic [OPERAND_W-1:0] req_a1,
  input  logic [OPERAND_W-1:0] req_b1,
  input  logic [1:0]           req_sub,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [RESULT_W-1:0]  rsp_result
);

  state_e                state_q, state_d;
  logic                  ptr_q;
  logic [OPERAND_W-1:0]  a_q, b_q;
  logic                  sub_q, id_q;
  logic [RESULT_W-1:0]   result_q;
  logic [RESULT_W-1:0]   alu_result;
  logic                  grant_id;
  logic                  accept;

  // ptr_q holds the last accepted id; on a tie the other requester wins.
  always_comb begin
    grant_id = 1'b0;
    case (req_valid)
      2'b01:   grant_id = 1'b0;
      2'b10:   grant_id = 1'b1;
      2'b11:   grant_id = ~ptr_q;
      default: grant_id = 1'b0;
    endcase
  end

  assign accept = (state_q == IDLE) && (|req_valid);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|req_valid) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = 2'b00;
    if (accept) req_ready[grant_id] = 1'b1;
    rsp_valid = (state_q == RESP);
  end

  adder_subtractor u_alu (
    .a_i      (a_q),
    .b_i      (b_q),
    .sub_i    (sub_q),
    .result_o (alu_result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q    <= 1'b1;
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      id_q     <= 1'b0;
      result_q <= '0;
    end else begin
      if (accept) begin
        ptr_q <= grant_id;
        id_q  <= grant_id;
        sub_q <= req_sub[grant_id];
        a_q   <= grant_id ? req_a1 : req_a0;
        b_q   <= grant_id ? req_b1 : req_b0;
      end
      if (state_q == EXEC) result_q <= alu_result;
    end
  end

  assign rsp_id     = id_q;
  assign rsp_result = result_q;

endmodule

// File: tb/tb_addsub_arbiter.sv
// tb/tb_addsub_arbiter.sv - directed vector table, corner sequences and randomized model check
module tb_addsub_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req_valid = 2'b00;
  logic [1:0] req_ready;
  logic [3:0] req_a0 = 4'd0, req_b0 = 4'd0, req_a1 = 4'd0, req_b1 = 4'd0;
  logic [1:0] req_sub = 2'b00;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic       rsp_id;
  logic [4:0] rsp_result;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  addsub_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a0     (req_a0),
    .req_b0     (req_b0),
    .req_a1     (req_a1),
    .req_b1     (req_b1),
    .req_sub    (req_sub),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result)
  );

  typedef struct {
    logic [1:0] valid;
    logic [3:0] a0, b0, a1, b1;
    logic [1:0] sub;
    logic [1:0] exp_ready;
    logic       exp_id;
    logic [4:0] exp_res;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int ref_res(input int a, input int b, input bit sub);
    return sub ? ((a - b) & 31) : (a + b);
  endfunction

  function automatic bit pick(input logic [1:0] v, input bit last);
    if (v == 2'b11) return !last;
    return v[1];
  endfunction

  task automatic do_reset();
    rst = 1'b1; req_valid = 2'b00; rsp_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Caller guarantees the DUT is idle; one full request/response round trip.
  task automatic do_op(input vec_t v);
    req_valid = v.valid; req_a0 = v.a0; req_b0 = v.b0;
    req_a1 = v.a1; req_b1 = v.b1; req_sub = v.sub;
    #1 chk("tbl_ready", req_ready, v.exp_ready);
    @(posedge clk); #1;
    req_valid = 2'b00; req_a0 = ~v.a0; req_b0 = ~v.b0; req_a1 = ~v.a1; req_b1 = ~v.b1; req_sub = ~v.sub;
    chk("tbl_exec_valid", rsp_valid, 0);
    @(posedge clk); #1;
    chk("tbl_rsp_valid", rsp_valid, 1);
    chk("tbl_rsp_id", rsp_id, v.exp_id);
    chk("tbl_rsp_result", rsp_result, v.exp_res);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("tbl_after_valid", rsp_valid, 0);
  endtask

  initial begin
    bit         busy, last, m_id;
    int         cnt, m_res;
    logic [1:0] exp_ready;

    tbl[0] = '{2'b01, 4'd9,  4'd8,  4'd0,  4'd0,  2'b00, 2'b01, 1'b0, 5'd17};
    tbl[1] = '{2'b10, 4'd0,  4'd0,  4'd3,  4'd5,  2'b10, 2'b10, 1'b1, 5'b11110};
    tbl[2] = '{2'b10, 4'd0,  4'd0,  4'd7,  4'd7,  2'b10, 2'b10, 1'b1, 5'b00000};
    tbl[3] = '{2'b11, 4'd1,  4'd1,  4'd15, 4'd15, 2'b00, 2'b01, 1'b0, 5'd2};
    tbl[4] = '{2'b11, 4'd1,  4'd1,  4'd15, 4'd15, 2'b00, 2'b10, 1'b1, 5'd30};
    tbl[5] = '{2'b11, 4'd1,  4'd1,  4'd15, 4'd15, 2'b00, 2'b01, 1'b0, 5'd2};
    tbl[6] = '{2'b01, 4'd0,  4'd15, 4'd0,  4'd0,  2'b01, 2'b01, 1'b0, 5'd17};
    tbl[7] = '{2'b11, 4'd15, 4'd0,  4'd0,  4'd1,  2'b11, 2'b10, 1'b1, 5'd31};
    tbl[8] = '{2'b01, 4'd15, 4'd15, 4'd0,  4'd0,  2'b00, 2'b01, 1'b0, 5'd30};

    do_reset();
    chk("rst_ready", req_ready, 2'b00);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_result", rsp_result, 0);

    foreach (tbl[i]) do_op(tbl[i]);

    // Held response: requester 1 wins the tie (last grant was 0), consumer stalls 4 cycles.
    req_valid = 2'b11; req_a1 = 4'd12; req_b1 = 4'd3; req_sub = 2'b10;
    #1 chk("stall_grant", req_ready, 2'b10);
    @(posedge clk); #1;
    chk("stall_exec_ready", req_ready, 2'b00);
    chk("stall_exec_valid", rsp_valid, 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("stall_valid", rsp_valid, 1);
      chk("stall_id", rsp_id, 1);
      chk("stall_result", rsp_result, 5'd9);
      chk("stall_ready", req_ready, 2'b00);
    end
    rsp_ready = 1'b1;
    #1 chk("xfer_cycle_ready", req_ready, 2'b00);
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("post_xfer_valid", rsp_valid, 0);
    chk("post_xfer_grant", req_ready, 2'b01);
    req_valid = 2'b00;

    // Reset in EXEC after a requester-0 grant: operation dropped, pointer back to favour requester 0.
    req_valid = 2'b01; req_a0 = 4'd5; req_b0 = 4'd5; req_sub = 2'b00;
    #1 chk("rexec_grant", req_ready, 2'b01);
    @(posedge clk); #1;
    req_valid = 2'b00; rsp_ready = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rexec_valid", rsp_valid, 0);
    chk("rexec_id", rsp_id, 0);
    chk("rexec_result", rsp_result, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rexec_no_rsp", rsp_valid, 0);
    end
    req_valid = 2'b11;
    #1 chk("rexec_tie_grant", req_ready, 2'b01);
    req_valid = 2'b00; rsp_ready = 1'b0;

    do_reset();
    busy = 0; last = 1; cnt = 0; m_id = 0; m_res = 0;
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      req_valid = 2'($urandom_range(0, 3));
      req_a0 = 4'($urandom); req_b0 = 4'($urandom);
      req_a1 = 4'($urandom); req_b1 = 4'($urandom);
      req_sub = 2'($urandom);
      rsp_ready = ($urandom_range(0, 2) != 0);
      #1;
      exp_ready = 2'b00;
      if (!busy && req_valid != 2'b00) exp_ready = pick(req_valid, last) ? 2'b10 : 2'b01;
      chk("rand_ready", req_ready, exp_ready);
      chk("rand_rsp_valid", rsp_valid, busy && cnt == 0);
      if (busy && cnt == 0) begin
        chk("rand_rsp_id", rsp_id, m_id);
        chk("rand_rsp_result", rsp_result, m_res);
      end
      if (!busy) begin
        if (req_valid != 2'b00) begin
          m_id  = pick(req_valid, last);
          last  = m_id;
          m_res = m_id ? ref_res(req_a1, req_b1, req_sub[1]) : ref_res(req_a0, req_b0, req_sub[0]);
          busy  = 1; cnt = 1;
        end
      end else if (cnt > 0) begin
        cnt--;
      end else if (rsp_ready) begin
        busy = 0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
